// File: rtl/affine_pkg.sv
// Shared types and sizes for the affine interpolation filter front end.
package affine_pkg;

  localparam int REF_ROWS   = 9;
  localparam int PEL_W      = 8;
  localparam int ROW_W      = REF_ROWS * PEL_W;
  localparam int FRAC_W     = 5;
  localparam int CUR_ADDR_W = 13;
  localparam int ROW_IDX_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    PUBLISH
  } load_state_t;

endpackage

// File: rtl/ref_row_stage.sv
// Nine-row staging buffer that collects one reference window row by row.
// Rows are written one at a time by index and read out all at once.
module ref_row_stage
  import affine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ROW_IDX_W-1:0] wr_idx,
  input  logic [ROW_W-1:0]     wr_data,
  output logic [ROW_W-1:0]     rows [0:REF_ROWS-1]
);

  // Write the addressed row; indices beyond the last row are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REF_ROWS; i++) rows[i] <= '0;
    end else begin
      for (int i = 0; i < REF_ROWS; i++) begin
        if (wr_en && wr_idx == ROW_IDX_W'(i)) rows[i] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/ref_window_loader.sv
// Reference window loader: takes one 4x4 sub-block request, fetches nine
// reference rows from the line SRAM, and publishes the finished window to
// the interpolation filter with a one-cycle export pulse.
module ref_window_loader
  import affine_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int STRIDE  = 16,
  parameter int MIN_GAP = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_base_addr,
  input  logic [FRAC_W-1:0]            req_frac_x,
  input  logic [FRAC_W-1:0]            req_frac_y,
  input  logic                         req_enab_prof,
  input  logic [CUR_ADDR_W-1:0]        req_cur_addr0,
  input  logic [CUR_ADDR_W-1:0]        req_cur_addr1,
  input  logic [CUR_ADDR_W-1:0]        req_cur_addr2,
  input  logic [CUR_ADDR_W-1:0]        req_cur_addr3,
  output logic                         ref_rd_en,
  output logic [ADDR_W-1:0]            ref_rd_addr,
  input  logic [ROW_W-1:0]             ref_rd_data,
  output logic                         en,
  output logic                         export_data_filter,
  output logic signed [ROW_W-1:0]      ref_Pel_4 [0:REF_ROWS-1],
  output logic [FRAC_W-1:0]            vect_4para_Frac_x,
  output logic [FRAC_W-1:0]            vect_4para_Frac_y,
  output logic                         enab_prof_in,
  output logic [CUR_ADDR_W-1:0]        cur_addr0_in,
  output logic [CUR_ADDR_W-1:0]        cur_addr1_in,
  output logic [CUR_ADDR_W-1:0]        cur_addr2_in,
  output logic [CUR_ADDR_W-1:0]        cur_addr3_in
);

  localparam int                   GAP_W     = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam logic [GAP_W-1:0]     GAP_SAT   = GAP_W'(MIN_GAP);
  localparam logic [ADDR_W-1:0]    ADDR_STEP = ADDR_W'(STRIDE);
  localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(REF_ROWS - 1);

  load_state_t            state;
  logic [ROW_IDX_W-1:0]   row_cnt;
  logic [ROW_IDX_W-1:0]   cap_idx;
  logic                   data_valid;
  logic [GAP_W-1:0]       gap_cnt;
  logic                   publish_now;
  logic                   accept;
  logic [ROW_W-1:0]       stage_rows [0:REF_ROWS-1];
  logic [ROW_W-1:0]       window     [0:REF_ROWS-1];

  logic [FRAC_W-1:0]      held_frac_x;
  logic [FRAC_W-1:0]      held_frac_y;
  logic                   held_prof;
  logic [CUR_ADDR_W-1:0]  held_cur0;
  logic [CUR_ADDR_W-1:0]  held_cur1;
  logic [CUR_ADDR_W-1:0]  held_cur2;
  logic [CUR_ADDR_W-1:0]  held_cur3;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign publish_now = ((state == DRAIN) || (state == PUBLISH)) && (gap_cnt >= GAP_SAT);

  ref_row_stage u_stage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_valid),
    .wr_idx  (cap_idx),
    .wr_data (ref_rd_data),
    .rows    (stage_rows)
  );

  // Staged window with the row landing this cycle bypassed in, so DRAIN can
  // publish on the same edge that the last row arrives.
  always_comb begin
    for (int i = 0; i < REF_ROWS; i++) begin
      window[i] = stage_rows[i];
      if (data_valid && cap_idx == ROW_IDX_W'(i)) window[i] = ref_rd_data;
    end
  end

  // Track which staging row the SRAM data returning this cycle belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      cap_idx    <= '0;
    end else begin
      data_valid <= ref_rd_en;
      if (accept)          cap_idx <= '0;
      else if (data_valid) cap_idx <= cap_idx + 1'b1;
    end
  end

  // Cycles since the last export, saturating so the first export is never held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                gap_cnt <= GAP_SAT;
    else if (publish_now)      gap_cnt <= '0;
    else if (gap_cnt < GAP_SAT) gap_cnt <= gap_cnt + 1'b1;
  end

  // Request FSM with registered read strobe, window outputs and handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      req_ready          <= 1'b1;
      ref_rd_en          <= 1'b0;
      ref_rd_addr        <= '0;
      row_cnt            <= '0;
      en                 <= 1'b0;
      export_data_filter <= 1'b0;
      vect_4para_Frac_x  <= '0;
      vect_4para_Frac_y  <= '0;
      enab_prof_in       <= 1'b0;
      cur_addr0_in       <= '0;
      cur_addr1_in       <= '0;
      cur_addr2_in       <= '0;
      cur_addr3_in       <= '0;
      held_frac_x        <= '0;
      held_frac_y        <= '0;
      held_prof          <= 1'b0;
      held_cur0          <= '0;
      held_cur1          <= '0;
      held_cur2          <= '0;
      held_cur3          <= '0;
      for (int i = 0; i < REF_ROWS; i++) ref_Pel_4[i] <= '0;
    end else begin
      export_data_filter <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            held_frac_x <= req_frac_x;
            held_frac_y <= req_frac_y;
            held_prof   <= req_enab_prof;
            held_cur0   <= req_cur_addr0;
            held_cur1   <= req_cur_addr1;
            held_cur2   <= req_cur_addr2;
            held_cur3   <= req_cur_addr3;
            ref_rd_en   <= 1'b1;
            ref_rd_addr <= req_base_addr;
            row_cnt     <= '0;
            req_ready   <= 1'b0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          if (row_cnt == LAST_ROW) begin
            ref_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            row_cnt     <= row_cnt + 1'b1;
            ref_rd_addr <= ref_rd_addr + ADDR_STEP;
          end
        end
        DRAIN, PUBLISH: begin
          if (publish_now) begin
            for (int i = 0; i < REF_ROWS; i++) ref_Pel_4[i] <= $signed(window[i]);
            vect_4para_Frac_x  <= held_frac_x;
            vect_4para_Frac_y  <= held_frac_y;
            enab_prof_in       <= held_prof;
            cur_addr0_in       <= held_cur0;
            cur_addr1_in       <= held_cur1;
            cur_addr2_in       <= held_cur2;
            cur_addr3_in       <= held_cur3;
            export_data_filter <= 1'b1;
            en                 <= 1'b1;
            req_ready          <= 1'b1;
            state              <= IDLE;
          end else begin
            state <= PUBLISH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ref_window_loader.sv
// Self-checking bench for ref_window_loader: SRAM model, request-level
// reference model and directed plus randomized request sequences.
module tb_ref_window_loader;

  localparam int STRIDE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [12:0] req_base_addr;
  logic [4:0]  req_frac_x, req_frac_y;
  logic        req_enab_prof;
  logic [12:0] req_cur_addr0, req_cur_addr1, req_cur_addr2, req_cur_addr3;
  logic        ref_rd_en;
  logic [12:0] ref_rd_addr;
  logic [71:0] ref_rd_data;
  logic        en, export_data_filter;
  logic signed [71:0] pel [0:8];
  logic [4:0]  vfx, vfy;
  logic        enab_prof_in;
  logic [12:0] cur0, cur1, cur2, cur3;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [71:0] mem [0:8191];

  bit          have_pending = 0;
  int          acc_edge = -100;
  int          acc_count = 0;
  logic [71:0] pend_win [0:8];
  logic [12:0] pend_base;
  logic [4:0]  pend_fx, pend_fy;
  logic        pend_prof;
  logic [12:0] pend_cur [0:3];

  logic [71:0] exp_win [0:8];
  logic [4:0]  exp_fx, exp_fy;
  logic        exp_prof, exp_en;
  logic [12:0] exp_cur [0:3];

  ref_window_loader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_base_addr(req_base_addr),
    .req_frac_x(req_frac_x), .req_frac_y(req_frac_y),
    .req_enab_prof(req_enab_prof),
    .req_cur_addr0(req_cur_addr0), .req_cur_addr1(req_cur_addr1),
    .req_cur_addr2(req_cur_addr2), .req_cur_addr3(req_cur_addr3),
    .ref_rd_en(ref_rd_en), .ref_rd_addr(ref_rd_addr), .ref_rd_data(ref_rd_data),
    .en(en), .export_data_filter(export_data_filter),
    .ref_Pel_4(pel),
    .vect_4para_Frac_x(vfx), .vect_4para_Frac_y(vfy),
    .enab_prof_in(enab_prof_in),
    .cur_addr0_in(cur0), .cur_addr1_in(cur1), .cur_addr2_in(cur2), .cur_addr3_in(cur3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // SRAM model: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (ref_rd_en) ref_rd_data <= mem[ref_rd_addr];
    else           ref_rd_data <= 72'({$urandom, $urandom, $urandom});
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: every request exports exactly ten cycles after the
  // accepting edge, reads row k in the k-th cycle after acceptance.
  always @(negedge clk) begin
    int rel;
    logic exp_rd_en, exp_export, exp_ready;
    logic [12:0] exp_addr;
    exp_addr = '0;
    if (!rst_n) begin
      have_pending = 0;
      for (int i = 0; i < 9; i++) exp_win[i] = '0;
      exp_fx = '0; exp_fy = '0; exp_prof = 1'b0; exp_en = 1'b0;
      for (int i = 0; i < 4; i++) exp_cur[i] = '0;
      exp_rd_en = 1'b0; exp_export = 1'b0; exp_ready = 1'b1;
      checkOutput("rst_addr", 128'(ref_rd_addr), 128'(0));
    end else begin
      rel = cyc - acc_edge;
      exp_rd_en = have_pending && rel >= 0 && rel <= 8;
      if (exp_rd_en) exp_addr = 13'((int'(pend_base) + rel * STRIDE) & 8191);
      exp_export = have_pending && rel == 10;
      if (exp_export) begin
        for (int i = 0; i < 9; i++) exp_win[i] = pend_win[i];
        exp_fx = pend_fx; exp_fy = pend_fy; exp_prof = pend_prof; exp_en = 1'b1;
        for (int i = 0; i < 4; i++) exp_cur[i] = pend_cur[i];
        have_pending = 0;
      end
      exp_ready = !have_pending;
      if (exp_rd_en) checkOutput("rd_addr", 128'(ref_rd_addr), 128'(exp_addr));
    end
    checkOutput("req_ready", 128'(req_ready), 128'(exp_ready));
    checkOutput("rd_en", 128'(ref_rd_en), 128'(exp_rd_en));
    checkOutput("export", 128'(export_data_filter), 128'(exp_export));
    checkOutput("en", 128'(en), 128'(exp_en));
    checkOutput("frac_x", 128'(vfx), 128'(exp_fx));
    checkOutput("frac_y", 128'(vfy), 128'(exp_fy));
    checkOutput("prof", 128'(enab_prof_in), 128'(exp_prof));
    checkOutput("cur0", 128'(cur0), 128'(exp_cur[0]));
    checkOutput("cur1", 128'(cur1), 128'(exp_cur[1]));
    checkOutput("cur2", 128'(cur2), 128'(exp_cur[2]));
    checkOutput("cur3", 128'(cur3), 128'(exp_cur[3]));
    for (int i = 0; i < 9; i++)
      checkOutput($sformatf("pel%0d", i), {56'b0, pel[i]}, {56'b0, exp_win[i]});
    if (rst_n && req_valid && exp_ready) begin
      pend_base = req_base_addr;
      for (int i = 0; i < 9; i++) pend_win[i] = mem[(int'(req_base_addr) + i * STRIDE) & 8191];
      pend_fx = req_frac_x; pend_fy = req_frac_y; pend_prof = req_enab_prof;
      pend_cur[0] = req_cur_addr0; pend_cur[1] = req_cur_addr1;
      pend_cur[2] = req_cur_addr2; pend_cur[3] = req_cur_addr3;
      acc_edge = cyc + 1;
      have_pending = 1;
      acc_count++;
    end
  end

  task automatic applyStimulus(input logic [12:0] base, input logic [4:0] fx, input logic [4:0] fy,
                               input logic prof, input logic [12:0] c0, input logic [12:0] c1,
                               input logic [12:0] c2, input logic [12:0] c3, input bit keep);
    int start, n;
    req_base_addr = base; req_frac_x = fx; req_frac_y = fy; req_enab_prof = prof;
    req_cur_addr0 = c0; req_cur_addr1 = c1; req_cur_addr2 = c2; req_cur_addr3 = c3;
    req_valid = 1'b1;
    start = acc_count;
    n = 0;
    while (acc_count == start && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_count == start) checkOutput("accept_timeout", 128'(0), 128'(1));
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (have_pending && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (have_pending) checkOutput("idle_timeout", 128'(1), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 72'({$urandom, $urandom, $urandom});
    for (int r = 0; r < 9; r++) mem[13'h100 + r * STRIDE] = {9{8'(r + 1)}};
    rst_n = 1'b0; req_valid = 1'b0; req_base_addr = '0; req_frac_x = '0; req_frac_y = '0;
    req_enab_prof = 1'b0; req_cur_addr0 = '0; req_cur_addr1 = '0; req_cur_addr2 = '0; req_cur_addr3 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single request");
    applyStimulus(13'h100, 5'd5, 5'd9, 1'b1, 13'h11, 13'h22, 13'h33, 13'h44, 1'b0);
    waitIdle();

    $display("[TB] address wrap");
    applyStimulus(13'h1FF0, 5'd15, 5'd0, 1'b0, 13'h1FFF, 13'h0, 13'h1234, 13'h0ABC, 1'b0);
    waitIdle();

    $display("[TB] back-to-back");
    applyStimulus(13'h0200, 5'd1, 5'd2, 1'b1, 13'h1, 13'h2, 13'h3, 13'h4, 1'b1);
    applyStimulus(13'h0A00, 5'd17, 5'd31, 1'b0, 13'h5, 13'h6, 13'h7, 13'h8, 1'b0);
    waitIdle();

    $display("[TB] busy stall");
    applyStimulus(13'h0300, 5'd3, 5'd4, 1'b0, 13'h10, 13'h20, 13'h30, 13'h40, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(13'h0F00, 5'd12, 5'd7, 1'b1, 13'h50, 13'h60, 13'h70, 13'h80, 1'b0);
    waitIdle();

    $display("[TB] reset mid-fetch");
    applyStimulus(13'h0400, 5'd8, 5'd8, 1'b1, 13'h99, 13'h98, 13'h97, 13'h96, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(13'h0500, 5'd6, 5'd10, 1'b0, 13'h1A, 13'h1B, 13'h1C, 13'h1D, 1'b0);
    waitIdle();

    $display("[TB] random requests");
    for (int k = 0; k < 14; k++) begin
      bit keep;
      keep = (k != 13) && ($urandom_range(0, 1) == 1);
      applyStimulus(13'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    1'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), 13'($urandom), keep);
      if (!keep) repeat ($urandom_range(0, 14)) @(posedge clk);
      #1;
    end
    waitIdle();
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
